// File: rtl/scara_motion_pkg.sv
// Motion command codes and sequencer state encoding shared by the SCARA cell
// sequencer, the motion FSM and their benches.
package scara_motion_pkg;

  localparam logic [2:0] CMD_MOVE  = 3'b000;
  localparam logic [2:0] CMD_PICK  = 3'b001;
  localparam logic [2:0] CMD_PLACE = 3'b010;
  localparam logic [2:0] CMD_HOME  = 3'b011;
  localparam logic [2:0] CMD_IDLE  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_PICK,
    ST_PLACE,
    ST_HOME,
    ST_WAIT_DONE,
    ST_ABORT_HOME
  } seq_state_e;

  // Command presented to the motion FSM while the sequencer sits in a state.
  function automatic logic [2:0] cmd_for_state(input seq_state_e s);
    case (s)
      ST_MOVE:                return CMD_MOVE;
      ST_PICK:                return CMD_PICK;
      ST_PLACE:               return CMD_PLACE;
      ST_HOME, ST_ABORT_HOME: return CMD_HOME;
      default:                return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/motion_dwell_timer.sv
// Loadable down-counter that stops at zero and flags it; used for both the
// per-command dwell and the completion timeout.
module motion_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pick_place_sequencer.sv
// Job-level sequencer: accepts an N-product job and issues MOVE/PICK/PLACE/HOME
// to the motion FSM per product, counting completions with timeout and abort.
module pick_place_sequencer #(
  parameter int DWELL   = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [CNT_W-1:0] job_count,
  output logic             job_ready,
  input  logic             abort,
  input  logic             product_complete,
  output logic [2:0]       motion_cmd,
  output logic             busy,
  output logic             job_done,
  output logic             fault,
  output logic [CNT_W-1:0] products_done
);

  import scara_motion_pkg::*;

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW_W-1:0] DWELL_LOAD   = DW_W'(DWELL - 1);
  localparam logic [TO_W-1:0] TIMEOUT_LOAD = TO_W'(TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] products_done_q, products_done_d;
  logic             fault_q, fault_d;
  logic             flag_q, flag_d;
  logic             job_done_q, job_done_d;
  logic [2:0]       motion_cmd_q, motion_cmd_d;

  logic             dwell_zero;
  logic             timeout_zero;
  logic             state_change;
  logic [CNT_W-1:0] done_inc;

  // Both timers reload whenever the state changes, so each state starts fresh.
  assign state_change = (state_d != state_q);

  motion_dwell_timer #(.W(DW_W)) u_dwell (
    .clock    (clock),
    .reset    (reset),
    .load     (state_change),
    .load_val (DWELL_LOAD),
    .en       (state_q != ST_IDLE),
    .zero     (dwell_zero)
  );

  motion_dwell_timer #(.W(TO_W)) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .load     (state_change),
    .load_val (TIMEOUT_LOAD),
    .en       (state_q == ST_WAIT_DONE),
    .zero     (timeout_zero)
  );

  // Saturating increment keeps products_done from passing the latched count.
  assign done_inc = (products_done_q == count_q) ? products_done_q
                                                 : products_done_q + CNT_W'(1);

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    products_done_d = products_done_q;
    fault_d         = fault_q;
    flag_d          = flag_q;
    job_done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          count_d         = job_count;
          products_done_d = '0;
          fault_d         = 1'b0;
          flag_d          = 1'b0;
          if (job_count == '0) begin
            job_done_d = 1'b1;
          end else begin
            state_d = ST_MOVE;
          end
        end
      end
      ST_MOVE: begin
        if (dwell_zero) state_d = ST_PICK;
      end
      ST_PICK: begin
        if (dwell_zero) state_d = ST_PLACE;
      end
      ST_PLACE: begin
        if (product_complete) flag_d = 1'b1;
        if (dwell_zero) state_d = ST_HOME;
      end
      ST_HOME: begin
        if (product_complete) flag_d = 1'b1;
        if (dwell_zero) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (flag_q || product_complete) begin
          flag_d          = 1'b0;
          products_done_d = done_inc;
          if (done_inc == count_q) begin
            job_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_MOVE;
          end
        end else if (timeout_zero) begin
          fault_d = 1'b1;
          state_d = ST_ABORT_HOME;
        end
      end
      ST_ABORT_HOME: begin
        if (dwell_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort outranks completion and timeout decided above in the same cycle.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_ABORT_HOME)) begin
      state_d         = ST_ABORT_HOME;
      products_done_d = products_done_q;
      fault_d         = fault_q;
      flag_d          = flag_q;
      job_done_d      = 1'b0;
    end
  end

  assign motion_cmd_d = cmd_for_state(state_d);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      count_q         <= '0;
      products_done_q <= '0;
      fault_q         <= 1'b0;
      flag_q          <= 1'b0;
      job_done_q      <= 1'b0;
      motion_cmd_q    <= CMD_IDLE;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      products_done_q <= products_done_d;
      fault_q         <= fault_d;
      flag_q          <= flag_d;
      job_done_q      <= job_done_d;
      motion_cmd_q    <= motion_cmd_d;
    end
  end

  assign job_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign motion_cmd    = motion_cmd_q;
  assign job_done      = job_done_q;
  assign fault         = fault_q;
  assign products_done = products_done_q;

endmodule
